// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit seven-segment scan driver with per-frame digit snapshot,
// leading-zero blanking and invalid-BCD dash display.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          BLANK_LEADING  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int unsigned PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [3:0] AN_OFF     = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
    localparam logic [6:0] SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF     = SEG_ACTIVE_LOW;

    logic [PW-1:0]   presc_q, presc_d;
    logic [1:0]      index_q, index_d;
    logic [3:0][3:0] shadow_q, shadow_d;
    logic            live_q, live_d;
    logic            tick;
    logic            snap;
    logic [3:0]      an_d;
    logic [6:0]      seg_d;
    logic [3:0]      digit;
    logic            blank;
    logic [6:0]      pattern;
    logic [3:0]      onehot;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    // State register: prescaler, slot index, digit snapshot and output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            index_q    <= 2'd3;
            shadow_q   <= '0;
            live_q     <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            index_q    <= index_d;
            shadow_q   <= shadow_d;
            live_q     <= live_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= DP_OFF;
            frame_done <= snap;
        end
    end

    // Next-state: prescaler wrap, slot rotation, snapshot at frame start.
    always_comb begin
        presc_d  = presc_q;
        index_d  = index_q;
        shadow_d = shadow_q;
        live_d   = live_q;
        snap     = 1'b0;
        tick     = enable && (presc_q == PRESC_MAX);
        if (enable) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        if (tick) begin
            index_d = index_q + 2'd1;
            live_d  = 1'b1;
            if (index_q == 2'd3) begin
                snap     = 1'b1;
                shadow_d = {thousands, hundreds, tens, ones};
            end
        end
    end

    // Output decode from next-state values so a new frame shows fresh digits.
    always_comb begin
        an_d    = AN_OFF;
        seg_d   = SEG_OFF;
        blank   = 1'b0;
        digit   = shadow_d[index_d];
        onehot  = 4'(4'b0001 << index_d);
        if (BLANK_LEADING) begin
            case (index_d)
                2'd3:    blank = (shadow_d[3] == 4'd0);
                2'd2:    blank = (shadow_d[3] == 4'd0) && (shadow_d[2] == 4'd0);
                2'd1:    blank = (shadow_d[3] == 4'd0) && (shadow_d[2] == 4'd0)
                              && (shadow_d[1] == 4'd0);
                default: blank = 1'b0;
            endcase
        end
        pattern = blank ? 7'h00 : seg_pattern(digit);
        if (enable && live_d) begin
            an_d  = AN_ACTIVE_LOW  ? ~onehot  : onehot;
            seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: two instances (blanking on/off), REFRESH_DIV = 4.
module tb_seg7_scan_driver;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] ones, tens, hundreds, thousands;
    logic [3:0] an, an_nb;
    logic [6:0] seg, seg_nb;
    logic       dp, dp_nb;
    logic       frame_done, frame_done_nb;

    int n_checks;
    int n_fail;

    seg7_scan_driver #(
        .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    seg7_scan_driver #(
        .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)
    ) dut_nb (
        .clk(clk), .reset(reset), .enable(enable),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .an(an_nb), .seg(seg_nb), .dp(dp_nb), .frame_done(frame_done_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [3:0] th, input logic [3:0] hu,
                              input logic [3:0] te, input logic [3:0] on);
        thousands = th;
        hundreds  = hu;
        tens      = te;
        ones      = on;
    endtask

    task automatic check_dark(input string tag);
        check_eq({tag, "_an"},     32'(an),         32'hF);
        check_eq({tag, "_seg"},    32'(seg),        32'h7F);
        check_eq({tag, "_an_nb"},  32'(an_nb),      32'hF);
        check_eq({tag, "_seg_nb"}, 32'(seg_nb),     32'h7F);
        check_eq({tag, "_fd"},     32'(frame_done), 32'h0);
    endtask

    // One full digit slot: the tick edge plus three hold cycles.
    task automatic expect_slot(input string tag, input logic [3:0] e_an,
                               input logic [6:0] e_seg, input logic [6:0] e_seg_nb);
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq({tag, "_an"},     32'(an),     32'(e_an));
            check_eq({tag, "_seg"},    32'(seg),    32'(e_seg));
            check_eq({tag, "_an_nb"},  32'(an_nb),  32'(e_an));
            check_eq({tag, "_seg_nb"}, 32'(seg_nb), 32'(e_seg_nb));
            check_eq({tag, "_fd"}, 32'(frame_done),
                     (c == 0 && e_an == 4'hE) ? 32'h1 : 32'h0);
            check_eq({tag, "_fd_nb"}, 32'(frame_done_nb),
                     (c == 0 && e_an == 4'hE) ? 32'h1 : 32'h0);
            if (c == 0) check_eq({tag, "_dp"}, 32'(dp), 32'h1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        #2 reset = 1'b0;
        step();
        check_dark("rst");
        check_eq("rst_dp", 32'(dp), 32'h1);
        step();
        reset  = 1'b1;
        enable = 1'b1;

        // Test 1: dark until the first tick, then 4 -> 3 -> 2 -> 1.
        for (int i = 0; i < 3; i++) begin
            step();
            check_dark("pre_tick");
        end
        expect_slot("t1_s0", 4'hE, 7'h19, 7'h19);
        expect_slot("t1_s1", 4'hD, 7'h30, 7'h30);
        expect_slot("t1_s2", 4'hB, 7'h24, 7'h24);
        expect_slot("t1_s3", 4'h7, 7'h79, 7'h79);
        expect_slot("t1_s0b", 4'hE, 7'h19, 7'h19);

        // Test 2: 0007 blanks the upper three; old frame completes first.
        set_digits(4'd0, 4'd0, 4'd0, 4'd7);
        expect_slot("t2_old1", 4'hD, 7'h30, 7'h30);
        expect_slot("t2_old2", 4'hB, 7'h24, 7'h24);
        expect_slot("t2_old3", 4'h7, 7'h79, 7'h79);
        expect_slot("t2_s0", 4'hE, 7'h78, 7'h78);
        expect_slot("t2_s1", 4'hD, 7'h7F, 7'h40);
        expect_slot("t2_s2", 4'hB, 7'h7F, 7'h40);
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        expect_slot("t2_s3", 4'h7, 7'h7F, 7'h40);
        expect_slot("t2z_s0", 4'hE, 7'h40, 7'h40);
        expect_slot("t2z_s1", 4'hD, 7'h7F, 7'h40);
        expect_slot("t2z_s2", 4'hB, 7'h7F, 7'h40);
        // Test 3: 0050 with and without blanking.
        set_digits(4'd0, 4'd0, 4'd5, 4'd0);
        expect_slot("t2z_s3", 4'h7, 7'h7F, 7'h40);
        expect_slot("t3_s0", 4'hE, 7'h40, 7'h40);
        expect_slot("t3_s1", 4'hD, 7'h12, 7'h12);
        expect_slot("t3_s2", 4'hB, 7'h7F, 7'h40);
        // Test 4: invalid tens shows a dash; hundreds zero stays lit.
        set_digits(4'd1, 4'd0, 4'hC, 4'd2);
        expect_slot("t3_s3", 4'h7, 7'h7F, 7'h40);
        expect_slot("t4_s0", 4'hE, 7'h24, 7'h24);
        expect_slot("t4_s1", 4'hD, 7'h3F, 7'h3F);
        expect_slot("t4_s2", 4'hB, 7'h40, 7'h40);
        // Invalid hundreds stops blanking below it.
        set_digits(4'd0, 4'hA, 4'd0, 4'd0);
        expect_slot("t4_s3", 4'h7, 7'h79, 7'h79);
        expect_slot("t4b_s0", 4'hE, 7'h40, 7'h40);
        expect_slot("t4b_s1", 4'hD, 7'h40, 7'h40);
        expect_slot("t4b_s2", 4'hB, 7'h3F, 7'h3F);
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        expect_slot("t4b_s3", 4'h7, 7'h7F, 7'h40);

        // Test 5: ones changes during slot 1; only the next frame sees it.
        expect_slot("t5_s0", 4'hE, 7'h19, 7'h19);
        fork
            begin
                repeat (2) @(negedge clk);
                ones = 4'd9;
            end
        join_none
        expect_slot("t5_s1", 4'hD, 7'h30, 7'h30);
        expect_slot("t5_s2", 4'hB, 7'h24, 7'h24);
        expect_slot("t5_s3", 4'h7, 7'h79, 7'h79);
        expect_slot("t5_new", 4'hE, 7'h10, 7'h10);
        expect_slot("t5_s1b", 4'hD, 7'h30, 7'h30);

        // Test 6: asynchronous reset mid slot 2.
        step();
        check_eq("t6_pre_an",  32'(an),  32'hB);
        check_eq("t6_pre_seg", 32'(seg), 32'h24);
        #2 reset = 1'b0;
        #1;
        check_dark("t6_async");
        step();
        check_dark("t6_hold");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_dark("t6_restart");
        end
        step();
        check_eq("t6_s0_an",  32'(an),         32'hE);
        check_eq("t6_s0_seg", 32'(seg),        32'h10);
        check_eq("t6_s0_fd",  32'(frame_done), 32'h1);
        step();
        check_eq("t6_s0b_an", 32'(an), 32'hE);

        // Enable dropped mid-slot: dark, frozen, then resume at the same point.
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_dark("t6_dis");
        end
        enable = 1'b1;
        step();
        check_eq("t6_res_an",  32'(an),  32'hE);
        check_eq("t6_res_seg", 32'(seg), 32'h10);
        check_eq("t6_res_fd",  32'(frame_done), 32'h0);
        step();
        check_eq("t6_res2_an", 32'(an), 32'hE);
        expect_slot("t6_s1", 4'hD, 7'h30, 7'h30);
        expect_slot("t6_s2", 4'hB, 7'h24, 7'h24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
